// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and instruction-field constants for the pipeline hazard controller.
// States, MIPS opcodes of interest and the bit positions of rs/rt/opcode in a 32-bit word.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LW    = 6'h23;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  // Only these opcodes read rt as a source; for the rest rt is a destination.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: stage status in, register enables/flushes and statistics out.
// The stage side uses master, the controller uses slave.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      IF_ID_instr;
  logic             ID_EX_memread;
  logic [4:0]       ID_EX_rt;
  logic             EX_MEM_PCSrc;
  logic             dmem_busy;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic [CNT_W-1:0] wait_count;
  logic             mem_timeout;

  modport master (
    output IF_ID_instr, ID_EX_memread, ID_EX_rt, EX_MEM_PCSrc, dmem_busy,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
           if_id_flush, id_ex_flush, ex_mem_flush,
           stall_count, flush_count, wait_count, mem_timeout
  );

  modport slave (
    input  IF_ID_instr, ID_EX_memread, ID_EX_rt, EX_MEM_PCSrc, dmem_busy,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
           if_id_flush, id_ex_flush, ex_mem_flush,
           stall_count, flush_count, wait_count, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the load in EX and the instruction in ID.
// A load to $0 never creates a dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic        memread_i,
  input  logic [4:0]  ld_rt_i,
  output logic        lu_o
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;

  assign op = instr_i[OP_MSB:OP_LSB];
  assign rs = instr_i[RS_MSB:RS_LSB];
  assign rt = instr_i[RT_MSB:RT_LSB];

  assign lu_o = memread_i && (ld_rt_i != 5'd0) &&
                ((ld_rt_i == rs) || ((ld_rt_i == rt) && reads_rt(op)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing FSM: stalls, flushes and memory-wait freezes, plus saturating
// statistics and a sticky watchdog on consecutive data-memory busy cycles.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  state_e           state_q, state_d, eval_state;
  logic [CNT_W-1:0] stall_q, flush_q, wait_q, timer_q;
  logic [CNT_W-1:0] stall_d, flush_d, wait_d, timer_d;
  logic             timeout_q, timeout_d;
  logic             lu;
  logic             pc_we, ifid_we, idex_we, exmem_we;
  logic             bubble, ifid_fl, idex_fl, exmem_fl;
  logic             stall_ev, flush_ev, wait_ev;

  hazard_detect u_hazard_detect (
    .instr_i   (bus.IF_ID_instr),
    .memread_i (bus.ID_EX_memread),
    .ld_rt_i   (bus.ID_EX_rt),
    .lu_o      (lu)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      stall_q   <= '0;
      flush_q   <= '0;
      wait_q    <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      wait_q    <= wait_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  // Leaving MEM_WAIT is evaluated as RUN in the same cycle so pending events act at once.
  always_comb begin
    state_d    = RUN;
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    idex_we    = 1'b1;
    exmem_we   = 1'b1;
    bubble     = 1'b0;
    ifid_fl    = 1'b0;
    idex_fl    = 1'b0;
    exmem_fl   = 1'b0;
    stall_ev   = 1'b0;
    flush_ev   = 1'b0;
    wait_ev    = 1'b0;
    eval_state = (state_q == MEM_WAIT) ? RUN : state_q;

    if (bus.dmem_busy) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      wait_ev  = 1'b1;
      state_d  = MEM_WAIT;
    end else if (bus.EX_MEM_PCSrc) begin
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
      exmem_fl = 1'b1;
      flush_ev = 1'b1;
      state_d  = FLUSH;
    end else if (lu && (eval_state != LOAD_STALL)) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      bubble   = 1'b1;
      stall_ev = 1'b1;
      state_d  = LOAD_STALL;
    end

    if (!rst_n) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      bubble   = 1'b0;
      ifid_fl  = 1'b0;
      idex_fl  = 1'b0;
      exmem_fl = 1'b0;
    end
  end

  // Timer holds the count of busy cycles before this one; the flag sets on busy cycle TIMEOUT.
  always_comb begin
    stall_d   = stall_ev ? sat_inc(stall_q) : stall_q;
    flush_d   = flush_ev ? sat_inc(flush_q) : flush_q;
    wait_d    = wait_ev  ? sat_inc(wait_q)  : wait_q;
    timer_d   = wait_ev  ? sat_inc(timer_q) : '0;
    timeout_d = timeout_q || (wait_ev && (timer_q >= TO_M1));
  end

  assign bus.pc_write     = pc_we;
  assign bus.if_id_write  = ifid_we;
  assign bus.id_ex_write  = idex_we;
  assign bus.ex_mem_write = exmem_we;
  assign bus.id_ex_bubble = bubble;
  assign bus.if_id_flush  = ifid_fl;
  assign bus.id_ex_flush  = idex_fl;
  assign bus.ex_mem_flush = exmem_fl;
  assign bus.stall_count  = stall_q;
  assign bus.flush_count  = flush_q;
  assign bus.wait_count   = wait_q;
  assign bus.mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two instances share stimulus, one with narrow
// counters for saturation, one with a short watchdog.
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] C_RST   = 8'h00;
  localparam logic [7:0] C_RUN   = 8'hF0;
  localparam logic [7:0] C_STALL = 8'h38;
  localparam logic [7:0] C_FLUSH = 8'hF7;
  localparam logic [7:0] C_BUSY  = 8'h00;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] ADD_R2  = {6'h00, 5'd2, 5'd4, 5'd3, 11'h020};
  localparam logic [31:0] ADD_R0  = {6'h00, 5'd0, 5'd0, 5'd3, 11'h020};
  localparam logic [31:0] ADDI_R2 = {6'h08, 5'd5, 5'd2, 16'h0004};
  localparam logic [31:0] SW_R2   = {6'h2B, 5'd5, 5'd2, 16'h0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(3))  ia ();
  pipe_hazard_ctrl_if #(.CNT_W(16)) ib ();

  pipe_hazard_ctrl #(.CNT_W(3), .TIMEOUT(7)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia.slave)
  );

  pipe_hazard_ctrl #(.CNT_W(16), .TIMEOUT(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib.slave)
  );

  wire [7:0] ctrl_a = {ia.pc_write, ia.if_id_write, ia.id_ex_write, ia.ex_mem_write,
                       ia.id_ex_bubble, ia.if_id_flush, ia.id_ex_flush, ia.ex_mem_flush};
  wire [7:0] ctrl_b = {ib.pc_write, ib.if_id_write, ib.id_ex_write, ib.ex_mem_write,
                       ib.id_ex_bubble, ib.if_id_flush, ib.id_ex_flush, ib.ex_mem_flush};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic mr, input logic [4:0] rt,
                       input logic pcsrc, input logic busy);
    ia.IF_ID_instr = instr; ia.ID_EX_memread = mr; ia.ID_EX_rt = rt;
    ia.EX_MEM_PCSrc = pcsrc; ia.dmem_busy = busy;
    ib.IF_ID_instr = instr; ib.ID_EX_memread = mr; ib.ID_EX_rt = rt;
    ib.EX_MEM_PCSrc = pcsrc; ib.dmem_busy = busy;
  endtask

  // Called just after a falling edge: check combinational controls, then cross one rising edge.
  task automatic cyc(input string tag, input logic [7:0] exp);
    #1 chk(tag, ctrl_a, exp);
    @(negedge clk);
  endtask

  initial begin
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("rst_ctrl", ctrl_a, C_RST);
    chk("rst_stall", ia.stall_count, 0);
    chk("rst_flush", ia.flush_count, 0);
    chk("rst_wait", ia.wait_count, 0);
    chk("rst_to", ib.mem_timeout, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cyc("run_def", C_RUN);

    drive(ADD_R2, 1'b1, 5'd2, 1'b0, 1'b0);
    cyc("lu_stall", C_STALL);
    chk("stall_cnt1", ia.stall_count, 1);
    cyc("ls_ignores_lu", C_RUN);
    chk("stall_cnt1b", ia.stall_count, 1);
    cyc("lu_again", C_STALL);
    chk("stall_cnt2", ia.stall_count, 2);
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("ls_to_run", C_RUN);

    drive(ADD_R0, 1'b1, 5'd0, 1'b0, 1'b0);
    cyc("lw_r0", C_RUN);
    drive(ADDI_R2, 1'b1, 5'd2, 1'b0, 1'b0);
    cyc("addi_rt", C_RUN);
    chk("stall_cnt_nochg", ia.stall_count, 2);
    drive(SW_R2, 1'b1, 5'd2, 1'b0, 1'b0);
    cyc("sw_rt", C_STALL);
    chk("stall_cnt3", ia.stall_count, 3);
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("idle1", C_RUN);

    drive(ADD_R2, 1'b1, 5'd2, 1'b1, 1'b0);
    cyc("pcsrc_over_lu", C_FLUSH);
    chk("flush_cnt1", ia.flush_count, 1);
    chk("stall_cnt_pc", ia.stall_count, 3);
    drive(ADD_R2, 1'b1, 5'd2, 1'b0, 1'b0);
    cyc("flush_then_lu", C_STALL);
    chk("stall_cnt4", ia.stall_count, 4);
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("idle2", C_RUN);

    drive(NOP, 1'b0, 5'd0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc("busy_pc", C_BUSY);
    chk("wait_cnt5", ia.wait_count, 5);
    chk("flush_cnt_hold", ia.flush_count, 1);
    drive(NOP, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc("flush_on_release", C_FLUSH);
    chk("flush_cnt2", ia.flush_count, 2);
    chk("b_to_set", ib.mem_timeout, 1);
    chk("a_to_clear", ia.mem_timeout, 0);
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("idle3", C_RUN);
    chk("b_to_sticky", ib.mem_timeout, 1);

    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b1);
    cyc("busy_r1", C_BUSY);
    cyc("busy_r2", C_BUSY);
    chk("wait_cnt7", ia.wait_count, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctrl", ctrl_a, C_RST);
    chk("arst_stall", ia.stall_count, 0);
    chk("arst_flush", ia.flush_count, 0);
    chk("arst_wait", ia.wait_count, 0);
    chk("arst_to", ib.mem_timeout, 0);
    @(negedge clk);
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    #1 chk("rel_ctrl", ctrl_a, C_RUN);
    @(negedge clk);
    cyc("after_rst", C_RUN);
    chk("after_rst_wait", ia.wait_count, 0);

    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      #1 chk("to_busy_ctrl", ctrl_b, C_BUSY);
      @(negedge clk);
      chk("to_flag", ib.mem_timeout, (k >= 4) ? 32'd1 : 32'd0);
    end
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 chk("to_release_ctrl", ctrl_b, C_RUN);
    @(negedge clk);
    chk("to_stays", ib.mem_timeout, 1);
    chk("b_wait6", ib.wait_count, 6);
    chk("a_to_below", ia.mem_timeout, 0);
    chk("a_wait6", ia.wait_count, 6);

    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("busy_sat", C_BUSY);
    chk("a_wait_sat", ia.wait_count, 7);
    chk("b_wait9", ib.wait_count, 9);
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("idle_end", C_RUN);
    chk("a_to_end", ia.mem_timeout, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
